// File: rtl/pgm_wr.sv
// pgm_wr: packet-generator write stage, sitting directly in front of pgm_rd.
//
// A packet whose head carries this module's MID (LMID) in [103:96] is a
// template. It is captured flit by flit into the 128x144 PGM RAM. Every other
// packet is forwarded to pgm_rd one cycle later, unchanged. Software starts a
// generation run through the cfg chain, and the run lasts sent_time_reg
// cycles. While a run is active or finished, incoming packets are dropped and
// counted. pgm_rd reads three mode levels: bypass, sent_start and
// sent_finish.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   in_wr_phv/_wr, out_wr_phv_alf      PHV from upstream (alf passes through)
//   in_wr_data/_wr, in_wr_valid/_wr    flit stream from upstream
//   out_wr_alf                         upstream almost-full (pass-through)
//   out_wr_phv/_wr, in_wr_phv_alf      PHV to pgm_rd
//   out_wr_data/_wr, out_wr_valid/_wr  flit stream to pgm_rd
//   in_wr_alf                          pgm_rd almost-full
//   pgm_bypass_flag / pgm_sent_start_flag / pgm_sent_finish_flag  mode levels
//   wr2ram_wr/_addr/_wdata             PGM RAM write port
//   cin_wr_data/_wr, cout_wr_ready     cfg chain input (ready passes through)
//   cout_wr_data/_wr, cin_wr_ready     cfg chain output
//   state_dbg                          current FSM state (see pgm_state_e)
//
// Handshake: a *_wr strobe qualifies its data for exactly the cycle it is
// high. There is no back-pressure inside this stage, and the alf/ready
// signals are only relayed to the neighbouring modules.
//
// Cfg flit layout (head flit, [133:132]=01): [126:124] opcode (010 write,
// 001 read), [103:96] target MID, [95:64] register address, [31:0] data.
// Matching writes are consumed. Matching reads are replaced by a response.
// Anything else on the chain is forwarded.
//
// The next module's MID (NMID = 61) belongs to pgm_rd and is not needed here.

module pgm_wr #(
  parameter logic [7:0] LMID = 8'd60
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic [1023:0] in_wr_phv,
  input  logic          in_wr_phv_wr,
  output logic          out_wr_phv_alf,

  input  logic [133:0]  in_wr_data,
  input  logic          in_wr_data_wr,
  input  logic          in_wr_valid,
  input  logic          in_wr_valid_wr,
  output logic          out_wr_alf,

  output logic [1023:0] out_wr_phv,
  output logic          out_wr_phv_wr,
  input  logic          in_wr_phv_alf,

  output logic [133:0]  out_wr_data,
  output logic          out_wr_data_wr,
  output logic          out_wr_valid,
  output logic          out_wr_valid_wr,
  input  logic          in_wr_alf,

  output logic          pgm_bypass_flag,
  output logic          pgm_sent_start_flag,
  output logic          pgm_sent_finish_flag,

  output logic          wr2ram_wr,
  output logic [6:0]    wr2ram_addr,
  output logic [143:0]  wr2ram_wdata,

  input  logic [133:0]  cin_wr_data,
  input  logic          cin_wr_data_wr,
  output logic          cout_wr_ready,

  output logic [133:0]  cout_wr_data,
  output logic          cout_wr_data_wr,
  input  logic          cin_wr_ready,

  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STORE    = 3'd1,
    S_OVF_DROP = 3'd2,  // template overflowed, discard through the real tail
    S_FWD      = 3'd3,
    S_GEN      = 3'd4,
    S_DONE     = 3'd5
  } pgm_state_e;

  pgm_state_e  state, state_n;

  logic [6:0]  wr_addr;
  logic        template_valid;
  logic        overflow;
  logic [6:0]  template_len;
  logic [31:0] sent_time_reg;
  logic [31:0] run_cnt;
  logic [31:0] drop_cnt;
  logic [1023:0] phv_hold;

  // Relayed flow-control
  assign out_wr_alf     = in_wr_alf;
  assign out_wr_phv_alf = in_wr_phv_alf;
  assign cout_wr_ready  = cin_wr_ready;

  // Mode levels are a pure decode of the state register, so they move one
  // cycle after the event that changed the state.
  assign pgm_bypass_flag      = (state == S_IDLE) || (state == S_STORE) ||
                                (state == S_OVF_DROP) || (state == S_FWD);
  assign pgm_sent_start_flag  = (state == S_GEN);
  assign pgm_sent_finish_flag = (state == S_DONE);
  assign state_dbg            = state;

  // Flit classification
  logic is_head, is_tail, is_tmpl_head;
  assign is_head      = in_wr_data_wr && (in_wr_data[133:132] == 2'b01);
  assign is_tail      = in_wr_data_wr && (in_wr_data[133:132] == 2'b10);
  assign is_tmpl_head = is_head && (in_wr_data[103:96] == LMID);

  // Cfg decode
  logic        cfg_hit, cfg_wr, cfg_rd;
  logic [31:0] cfg_addr;
  logic        soft_rst, start_cmd, sent_wr;
  assign cfg_hit   = cin_wr_data_wr && (cin_wr_data[133:132] == 2'b01) &&
                     (cin_wr_data[103:96] == LMID);
  assign cfg_wr    = cfg_hit && (cin_wr_data[126:124] == 3'b010);
  assign cfg_rd    = cfg_hit && (cin_wr_data[126:124] == 3'b001);
  assign cfg_addr  = cin_wr_data[95:64];
  assign soft_rst  = cfg_wr && (cfg_addr == 32'h0) && cin_wr_data[0];
  assign sent_wr   = cfg_wr && (cfg_addr == 32'h2);
  // Start is only legal with a stored template, from IDLE or DONE.
  assign start_cmd = cfg_wr && (cfg_addr == 32'h1) && cin_wr_data[0] &&
                     template_valid && ((state == S_IDLE) || (state == S_DONE));

  logic [6:0] next_addr;
  assign next_addr = wr_addr + 7'd1;

  // Next-state and per-cycle actions
  logic       fwd_en, ram_we, hdr_force, tmpl_clear, tmpl_done, ovf_set;
  logic       drop_head, run_inc, run_clr;
  logic [6:0] ram_addr_n;

  always_comb begin
    state_n    = state;
    fwd_en     = 1'b0;
    ram_we     = 1'b0;
    hdr_force  = 1'b0;
    tmpl_clear = 1'b0;
    tmpl_done  = 1'b0;
    ovf_set    = 1'b0;
    drop_head  = 1'b0;
    run_inc    = 1'b0;
    run_clr    = 1'b0;
    ram_addr_n = wr_addr;

    if (soft_rst) begin
      state_n = S_IDLE;
    end else if (start_cmd) begin
      // Start wins over a head arriving in the same cycle. That packet
      // belongs to the run now, so it is dropped and counted.
      state_n   = S_GEN;
      run_clr   = 1'b1;
      drop_head = is_head;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (is_tmpl_head) begin
            tmpl_clear = 1'b1;
            ram_we     = 1'b1;
            ram_addr_n = 7'd0;
            state_n    = S_STORE;
          end else if (is_head) begin
            fwd_en  = 1'b1;
            state_n = S_FWD;
          end
        end
        S_STORE: begin
          if (in_wr_data_wr) begin
            ram_we     = 1'b1;
            ram_addr_n = next_addr;
            if (is_tail) begin
              tmpl_done = 1'b1;
              state_n   = S_IDLE;
            end else if (next_addr == 7'd127) begin
              // The RAM is full. Close the template with a forced tail.
              hdr_force = 1'b1;
              ovf_set   = 1'b1;
              tmpl_done = 1'b1;
              state_n   = S_OVF_DROP;
            end
          end
        end
        S_OVF_DROP: begin
          if (is_tail) state_n = S_IDLE;
        end
        S_FWD: begin
          if (in_wr_data_wr) begin
            fwd_en = 1'b1;
            if (is_tail) state_n = S_IDLE;
          end
        end
        S_GEN: begin
          drop_head = is_head;
          if ((sent_time_reg != 32'h0) && (run_cnt == sent_time_reg - 32'd1))
            state_n = S_DONE;
          else
            run_inc = 1'b1;
        end
        S_DONE: begin
          drop_head = is_head;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Template bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr        <= 7'd0;
      template_valid <= 1'b0;
      overflow       <= 1'b0;
      template_len   <= 7'd0;
    end else if (soft_rst) begin
      wr_addr        <= 7'd0;
      template_valid <= 1'b0;
      overflow       <= 1'b0;
      template_len   <= 7'd0;
    end else begin
      if (ram_we)     wr_addr <= ram_addr_n;
      if (tmpl_clear) template_valid <= 1'b0;
      if (tmpl_done) begin
        template_valid <= 1'b1;
        template_len   <= ram_addr_n + 7'd1;  // a 128-flit template wraps to 0
      end
      if (ovf_set)    overflow <= 1'b1;
    end
  end

  // Run and drop counters. sent_time_reg survives a soft reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt       <= 32'h0;
      drop_cnt      <= 32'h0;
      sent_time_reg <= 32'h0;
    end else begin
      if (sent_wr) sent_time_reg <= cin_wr_data[31:0];
      if (soft_rst) begin
        run_cnt  <= 32'h0;
        drop_cnt <= 32'h0;
      end else begin
        if (run_clr)      run_cnt <= 32'h0;
        else if (run_inc) run_cnt <= run_cnt + 32'd1;
        if (drop_head && (drop_cnt != 32'hFFFF_FFFF)) drop_cnt <= drop_cnt + 32'd1;
      end
    end
  end

  // Forwarding datapath. The PHV is taken from the same cycle when its strobe
  // is present; otherwise the most recent PHV is reused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wr_data     <= '0;
      out_wr_data_wr  <= 1'b0;
      out_wr_valid    <= 1'b0;
      out_wr_valid_wr <= 1'b0;
      out_wr_phv      <= '0;
      out_wr_phv_wr   <= 1'b0;
      phv_hold        <= '0;
    end else if (soft_rst) begin
      out_wr_data     <= '0;
      out_wr_data_wr  <= 1'b0;
      out_wr_valid    <= 1'b0;
      out_wr_valid_wr <= 1'b0;
      out_wr_phv      <= '0;
      out_wr_phv_wr   <= 1'b0;
      phv_hold        <= '0;
    end else begin
      out_wr_data_wr  <= fwd_en;
      out_wr_phv_wr   <= fwd_en;
      out_wr_valid_wr <= fwd_en && in_wr_valid_wr;
      if (fwd_en) begin
        out_wr_data  <= in_wr_data;
        out_wr_valid <= in_wr_valid;
        out_wr_phv   <= in_wr_phv_wr ? in_wr_phv : phv_hold;
      end
      if (in_wr_phv_wr) phv_hold <= in_wr_phv;
    end
  end

  // RAM write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr2ram_wr    <= 1'b0;
      wr2ram_addr  <= 7'd0;
      wr2ram_wdata <= '0;
    end else if (soft_rst) begin
      wr2ram_wr    <= 1'b0;
      wr2ram_addr  <= 7'd0;
      wr2ram_wdata <= '0;
    end else begin
      wr2ram_wr <= ram_we;
      if (ram_we) begin
        wr2ram_addr <= ram_addr_n;
        if (hdr_force) wr2ram_wdata <= {10'b0, 2'b10, in_wr_data[131:0]};
        else           wr2ram_wdata <= {10'b0, in_wr_data};
      end
    end
  end

  // Cfg read mux and registered cfg output
  logic [31:0] rd_value;
  always_comb begin
    rd_value = 32'hFFFF_FFFF;
    case (cfg_addr)
      32'h2:   rd_value = sent_time_reg;
      32'h3:   rd_value = {25'b0, template_len};
      32'h4:   rd_value = {28'b0, pgm_sent_finish_flag, pgm_sent_start_flag,
                           overflow, template_valid};
      32'h5:   rd_value = drop_cnt;
      32'h6:   rd_value = run_cnt;
      default: rd_value = 32'hFFFF_FFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_wr_data    <= '0;
      cout_wr_data_wr <= 1'b0;
    end else if (cfg_rd) begin
      cout_wr_data    <= {cin_wr_data[133:128], 4'b1011, cin_wr_data[123:32], rd_value};
      cout_wr_data_wr <= 1'b1;
    end else if (cfg_wr) begin
      cout_wr_data_wr <= 1'b0;  // writes addressed to us end here
    end else begin
      cout_wr_data_wr <= cin_wr_data_wr;
      if (cin_wr_data_wr) cout_wr_data <= cin_wr_data;
    end
  end

endmodule

// File: tb/tb_pgm_wr.sv
// Directed bench for pgm_wr. Stimulus runs as a linear sequence. Expected
// forwarded flits, RAM writes and cfg responses are queued when they are
// driven. A monitor pops each queue whenever the matching strobe appears.
module tb_pgm_wr;
  localparam logic [7:0] LMID = 8'd60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1023:0] in_wr_phv = '0;
  logic          in_wr_phv_wr = 1'b0;
  logic          out_wr_phv_alf;
  logic [133:0]  in_wr_data = '0;
  logic          in_wr_data_wr = 1'b0;
  logic          in_wr_valid = 1'b0;
  logic          in_wr_valid_wr = 1'b0;
  logic          out_wr_alf;
  logic [1023:0] out_wr_phv;
  logic          out_wr_phv_wr;
  logic          in_wr_phv_alf = 1'b0;
  logic [133:0]  out_wr_data;
  logic          out_wr_data_wr;
  logic          out_wr_valid;
  logic          out_wr_valid_wr;
  logic          in_wr_alf = 1'b0;
  logic          pgm_bypass_flag, pgm_sent_start_flag, pgm_sent_finish_flag;
  logic          wr2ram_wr;
  logic [6:0]    wr2ram_addr;
  logic [143:0]  wr2ram_wdata;
  logic [133:0]  cin_wr_data = '0;
  logic          cin_wr_data_wr = 1'b0;
  logic          cout_wr_ready;
  logic [133:0]  cout_wr_data;
  logic          cout_wr_data_wr;
  logic          cin_wr_ready = 1'b0;
  logic [2:0]    state_dbg;

  int checks = 0;
  int failures = 0;

  logic [135:0]  exp_fwd_q[$];
  logic [1023:0] exp_phv_q[$];
  logic [150:0]  exp_ram_q[$];
  logic [133:0]  exp_cfg_q[$];

  pgm_wr #(.LMID(LMID)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_wr_phv(in_wr_phv), .in_wr_phv_wr(in_wr_phv_wr), .out_wr_phv_alf(out_wr_phv_alf),
    .in_wr_data(in_wr_data), .in_wr_data_wr(in_wr_data_wr),
    .in_wr_valid(in_wr_valid), .in_wr_valid_wr(in_wr_valid_wr), .out_wr_alf(out_wr_alf),
    .out_wr_phv(out_wr_phv), .out_wr_phv_wr(out_wr_phv_wr), .in_wr_phv_alf(in_wr_phv_alf),
    .out_wr_data(out_wr_data), .out_wr_data_wr(out_wr_data_wr),
    .out_wr_valid(out_wr_valid), .out_wr_valid_wr(out_wr_valid_wr), .in_wr_alf(in_wr_alf),
    .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
    .pgm_sent_finish_flag(pgm_sent_finish_flag),
    .wr2ram_wr(wr2ram_wr), .wr2ram_addr(wr2ram_addr), .wr2ram_wdata(wr2ram_wdata),
    .cin_wr_data(cin_wr_data), .cin_wr_data_wr(cin_wr_data_wr), .cout_wr_ready(cout_wr_ready),
    .cout_wr_data(cout_wr_data), .cout_wr_data_wr(cout_wr_data_wr), .cin_wr_ready(cin_wr_ready),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog obs=timeout exp=finish checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs[191:0], exp[191:0]);
    end
  endtask

  function automatic logic [133:0] mk_flit(input logic [1:0] hdr, input logic [7:0] mid);
    logic [133:0] f;
    f[31:0]    = $urandom;
    f[63:32]   = $urandom;
    f[95:64]   = $urandom;
    f[127:96]  = $urandom;
    f[133:128] = 6'($urandom_range(0, 63));
    f[133:132] = hdr;
    f[103:96]  = mid;
    return f;
  endfunction

  function automatic logic [133:0] mk_cfg(input logic [2:0] op, input logic [7:0] mid,
                                          input logic [31:0] addr, input logic [31:0] val);
    logic [133:0] f;
    f = mk_flit(2'b01, mid);
    f[126:124] = op;
    f[95:64]   = addr;
    f[31:0]    = val;
    return f;
  endfunction

  // Driver tasks
  // mode 0: expect forwarding, mode 1: expect RAM capture, mode 2: expect drop
  task automatic send_pkt(input int n, input logic [7:0] mid, input int mode);
    logic [133:0]  f;
    logic [1023:0] p;
    logic [143:0]  w;
    logic [1:0]    hdr;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hdr = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
      f = mk_flit(hdr, (i == 0) ? mid : 8'($urandom));
      p = '0;
      p[31:0] = $urandom;
      in_wr_data = f; in_wr_data_wr = 1'b1;
      in_wr_phv = p;  in_wr_phv_wr = 1'b1;
      in_wr_valid = (i == n - 1); in_wr_valid_wr = (i == n - 1);
      if (mode == 0) begin
        exp_fwd_q.push_back({(i == n - 1), (i == n - 1), f});
        exp_phv_q.push_back(p);
      end else if (mode == 1 && i < 128) begin
        w = {10'b0, f};
        if (i == 127 && i != n - 1) w[133:132] = 2'b10;
        exp_ram_q.push_back({7'(i), w});
      end
    end
    @(negedge clk);
    in_wr_data_wr = 1'b0; in_wr_phv_wr = 1'b0;
    in_wr_valid = 1'b0; in_wr_valid_wr = 1'b0;
    check("fwd_latency", exp_fwd_q.size(), 0);
    check("ram_latency", exp_ram_q.size(), 0);
  endtask

  task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] val);
    @(negedge clk);
    cin_wr_data = mk_cfg(3'b010, LMID, addr, val); cin_wr_data_wr = 1'b1;
    @(negedge clk);
    cin_wr_data_wr = 1'b0;
  endtask

  task automatic cfg_rd(input logic [31:0] addr, input logic [31:0] val);
    logic [133:0] d;
    d = mk_cfg(3'b001, LMID, addr, $urandom);
    exp_cfg_q.push_back({d[133:128], 4'b1011, d[123:32], val});
    @(negedge clk);
    cin_wr_data = d; cin_wr_data_wr = 1'b1;
    @(negedge clk);
    cin_wr_data_wr = 1'b0;
    check("cfg_latency", exp_cfg_q.size(), 0);
  endtask

  task automatic check_flags(input string tag, input logic byp, input logic st, input logic fin);
    check({tag, "_bypass"}, pgm_bypass_flag, byp);
    check({tag, "_start"}, pgm_sent_start_flag, st);
    check({tag, "_finish"}, pgm_sent_finish_flag, fin);
  endtask

  // Scoreboard monitor
  always begin
    @(posedge clk);
    #2;
    if (out_wr_data_wr || out_wr_phv_wr) check("phv_wr_mirror", out_wr_phv_wr, out_wr_data_wr);
    if (out_wr_data_wr) begin
      check("fwd_expected", exp_fwd_q.size() != 0, 1'b1);
      if (exp_fwd_q.size() != 0) begin
        check("fwd_flit", {out_wr_valid, out_wr_valid_wr, out_wr_data}, exp_fwd_q.pop_front());
        check("fwd_phv", out_wr_phv, exp_phv_q.pop_front());
      end
    end
    if (wr2ram_wr) begin
      check("ram_expected", exp_ram_q.size() != 0, 1'b1);
      if (exp_ram_q.size() != 0) check("ram_write", {wr2ram_addr, wr2ram_wdata}, exp_ram_q.pop_front());
    end
    if (cout_wr_data_wr) begin
      check("cfg_expected", exp_cfg_q.size() != 0, 1'b1);
      if (exp_cfg_q.size() != 0) check("cfg_out", cout_wr_data, exp_cfg_q.pop_front());
    end
  end

  // Directed sequence
  initial begin
    logic [133:0] d;

    // Reset state
    repeat (3) @(posedge clk);
    #3;
    check("rst_data_wr", out_wr_data_wr, 1'b0);
    check("rst_ram_wr", wr2ram_wr, 1'b0);
    check("rst_cfg_wr", cout_wr_data_wr, 1'b0);
    check("rst_data", out_wr_data, '0);
    check("rst_state", state_dbg, 3'd0);
    check_flags("rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cfg_rd(32'h2, 32'h0);

    // Template store: 4 flits at addr 0..3
    send_pkt(4, LMID, 1);
    cfg_rd(32'h3, 32'd4);
    cfg_rd(32'h4, 32'h1);

    // Bypass forwarding
    send_pkt(3, 8'd5, 0);
    check_flags("bypass", 1'b1, 1'b0, 1'b0);

    // Timed run of 10 cycles
    cfg_wr(32'h2, 32'd10);
    @(negedge clk);
    cin_wr_data = mk_cfg(3'b010, LMID, 32'h1, 32'h1); cin_wr_data_wr = 1'b1;
    @(posedge clk); #3;
    check_flags("start", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    cin_wr_data_wr = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #3;
      check("run_finish", pgm_sent_finish_flag, logic'(k == 10));
      check("run_start", pgm_sent_start_flag, logic'(k != 10));
    end
    cfg_rd(32'h6, 32'd9);
    cfg_rd(32'h4, 32'h9);

    // Drops during an open-ended run
    cfg_wr(32'h2, 32'd0);
    cfg_wr(32'h1, 32'h1);
    check_flags("gen", 1'b0, 1'b1, 1'b0);
    send_pkt(3, LMID, 2);
    send_pkt(2, 8'd5, 2);
    cfg_rd(32'h5, 32'd2);
    cfg_rd(32'h4, 32'h5);

    // Soft reset from GEN, then start without a template
    cfg_wr(32'h0, 32'h1);
    check_flags("srst_gen", 1'b1, 1'b0, 1'b0);
    cfg_rd(32'h4, 32'h0);
    cfg_rd(32'h5, 32'h0);
    cfg_rd(32'h3, 32'h0);
    cfg_wr(32'h1, 32'h1);
    check_flags("nostart", 1'b1, 1'b0, 1'b0);
    check("nostart_state", state_dbg, 3'd0);

    // Overflowing template: 130 flits, 128 writes, forced tail at 127
    send_pkt(130, LMID, 1);
    cfg_rd(32'h4, 32'h3);
    cfg_rd(32'h3, 32'h0);

    // Start together with a template head: start wins, packet dropped
    cfg_wr(32'h2, 32'd5);
    @(negedge clk);
    cin_wr_data = mk_cfg(3'b010, LMID, 32'h1, 32'h1); cin_wr_data_wr = 1'b1;
    in_wr_data = mk_flit(2'b01, LMID); in_wr_data_wr = 1'b1;
    @(negedge clk);
    cin_wr_data_wr = 1'b0;
    in_wr_data = mk_flit(2'b10, 8'd0);
    @(negedge clk);
    in_wr_data_wr = 1'b0;
    for (int k = 0; k < 20 && !pgm_sent_finish_flag; k++) begin
      @(posedge clk); #3;
    end
    check("collide_finish", pgm_sent_finish_flag, 1'b1);
    cfg_rd(32'h5, 32'd1);
    cfg_rd(32'h4, 32'hB);

    // Soft reset in DONE keeps sent_time_reg
    cfg_wr(32'h0, 32'h1);
    check_flags("srst_done", 1'b1, 1'b0, 1'b0);
    cfg_rd(32'h2, 32'd5);
    cfg_rd(32'h4, 32'h0);

    // Unknown register and foreign cfg traffic
    cfg_rd(32'h7, 32'hFFFF_FFFF);
    d = mk_cfg(3'b010, 8'd7, 32'h2, 32'd99);
    exp_cfg_q.push_back(d);
    @(negedge clk);
    cin_wr_data = d; cin_wr_data_wr = 1'b1;
    @(negedge clk);
    cin_wr_data_wr = 1'b0;
    check("cfg_fwd_latency", exp_cfg_q.size(), 0);
    cfg_rd(32'h2, 32'd5);

    // Flow-control pass-through
    in_wr_alf = 1'b1; in_wr_phv_alf = 1'b1; cin_wr_ready = 1'b1;
    #1;
    check("alf_hi", {out_wr_alf, out_wr_phv_alf, cout_wr_ready}, 3'b111);
    in_wr_phv_alf = 1'b0;
    #1;
    check("alf_mix", {out_wr_alf, out_wr_phv_alf, cout_wr_ready}, 3'b101);

    repeat (3) @(posedge clk);
    #3;
    check("fwd_q_empty", exp_fwd_q.size(), 0);
    check("ram_q_empty", exp_ram_q.size(), 0);
    check("cfg_q_empty", exp_cfg_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
